// File: rtl/ucie_pkg.sv
// Shared definitions for the UCIe configuration CSR block: register offsets,
// reset values, EVENT bit positions and the request FSM state type.
package ucie_pkg;

  localparam logic [7:0] ADDR_CTRL      = 8'h00;
  localparam logic [7:0] ADDR_LINK_CFG  = 8'h04;
  localparam logic [7:0] ADDR_FC_CFG    = 8'h08;
  localparam logic [7:0] ADDR_STATUS    = 8'h10;
  localparam logic [7:0] ADDR_EVENT     = 8'h14;
  localparam logic [7:0] ADDR_IRQ_EN    = 8'h18;
  localparam logic [7:0] ADDR_SNAP_CTRL = 8'h20;
  localparam logic [7:0] ADDR_SNAP_TX   = 8'h24;
  localparam logic [7:0] ADDR_SNAP_RX   = 8'h28;
  localparam logic [7:0] ADDR_SNAP_ERR  = 8'h2C;
  localparam logic [7:0] ADDR_UPTIME    = 8'h30;

  localparam logic [7:0]  CREDIT_RST     = 8'd8;
  localparam logic [15:0] FC_TIMEOUT_RST = 16'hFFFF;

  localparam int unsigned EV_W         = 3;
  localparam int unsigned EV_LINK_DOWN = 0;
  localparam int unsigned EV_THERMAL   = 1;
  localparam int unsigned EV_ERROR     = 2;

  typedef enum logic {
    IDLE,
    RESP
  } csr_state_e;

  // Replace the bytes of cur selected by wstrb with the matching bytes of wdata.
  function automatic logic [31:0] strobe_merge(input logic [31:0] cur,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  wstrb);
    logic [31:0] res;
    res = cur;
    for (int unsigned i = 0; i < 4; i++) begin
      if (wstrb[i]) res[8*i +: 8] = wdata[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/ucie_csr_event_detect.sv
// Link event edge detection with sticky W1C EVENT bits (set wins over clear)
// and a saturating link-uptime counter.
module ucie_csr_event_detect
  import ucie_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            link_up,
  input  logic            thermal,
  input  logic [31:0]     err_count,
  input  logic            clr_valid,
  input  logic [EV_W-1:0] clr_mask,
  output logic [EV_W-1:0] events,
  output logic [31:0]     uptime
);

  logic            primed;
  logic            prev_link_up;
  logic            prev_thermal;
  logic [31:0]     prev_err_count;
  logic [EV_W-1:0] set_bits;
  logic [EV_W-1:0] clr_bits;

  // Prev-sample registers are only trustworthy once primed.
  always_comb begin
    set_bits               = '0;
    set_bits[EV_LINK_DOWN] = primed && prev_link_up && !link_up;
    set_bits[EV_THERMAL]   = primed && !prev_thermal && thermal;
    set_bits[EV_ERROR]     = primed && (prev_err_count != err_count);
    clr_bits               = clr_valid ? clr_mask : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      primed         <= 1'b0;
      prev_link_up   <= 1'b0;
      prev_thermal   <= 1'b0;
      prev_err_count <= '0;
      events         <= '0;
      uptime         <= '0;
    end else begin
      primed         <= 1'b1;
      prev_link_up   <= link_up;
      prev_thermal   <= thermal;
      prev_err_count <= err_count;
      events         <= (events & ~clr_bits) | set_bits;
      if (!link_up) begin
        uptime <= '0;
      end else if (uptime != '1) begin
        uptime <= uptime + 32'd1;
      end
    end
  end

endmodule

// File: rtl/ucie_config_csr.sv
// Memory-mapped configuration/status register block for the UCIe controller,
// with a two-state request/response handshake and a level interrupt.
module ucie_config_csr
  import ucie_pkg::*;
#(
  parameter int unsigned NUM_PROTOCOLS = 4,
  parameter logic [7:0]  SPEED_RST     = 8'd32,
  parameter logic [7:0]  WIDTH_RST     = 8'd16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     csr_req_valid,
  output logic                     csr_req_ready,
  input  logic                     csr_req_write,
  input  logic [7:0]               csr_req_addr,
  input  logic [31:0]              csr_req_wdata,
  input  logic [3:0]               csr_req_wstrb,
  output logic                     csr_rsp_valid,
  input  logic                     csr_rsp_ready,
  output logic [31:0]              csr_rsp_rdata,
  output logic                     csr_rsp_err,
  output logic [NUM_PROTOCOLS-1:0] cfg_protocol_enable,
  output logic                     cfg_pam4_enable,
  output logic                     cfg_ml_optimization_enable,
  output logic                     cfg_quarter_rate_enable,
  output logic [7:0]               cfg_target_speed,
  output logic [7:0]               cfg_target_width,
  output logic [7:0]               cfg_credit_return_threshold,
  output logic [15:0]              cfg_flow_control_timeout,
  input  logic                     sts_link_up,
  input  logic [3:0]               sts_link_state,
  input  logic [7:0]               sts_current_speed,
  input  logic                     sts_thermal_throttle,
  input  logic [31:0]              sts_packet_count_tx,
  input  logic [31:0]              sts_packet_count_rx,
  input  logic [31:0]              sts_error_count_total,
  output logic                     irq
);

  csr_state_e      state, state_nx;
  logic            accept;
  logic [31:0]     rd_word;
  logic [31:0]     wr_word;
  logic [31:0]     rdata_d;
  logic            addr_ok;
  logic            addr_ro;
  logic            err_d;
  logic            do_wr;
  logic            w1c_valid;
  logic [EV_W-1:0] w1c_mask;
  logic [EV_W-1:0] events;
  logic [EV_W-1:0] irq_en;
  logic [31:0]     uptime;
  logic [31:0]     snap_tx;
  logic [31:0]     snap_rx;
  logic [31:0]     snap_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    csr_req_ready = 1'b0;
    csr_rsp_valid = 1'b0;
    accept        = 1'b0;
    case (state)
      IDLE: begin
        csr_req_ready = !rst;
        accept        = csr_req_valid && csr_req_ready;
        if (accept) state_nx = RESP;
      end
      RESP: begin
        csr_rsp_valid = 1'b1;
        if (csr_rsp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Misaligned addresses never match an offset, so they fall into the error path.
  always_comb begin
    rd_word = '0;
    addr_ok = 1'b0;
    addr_ro = 1'b0;
    case (csr_req_addr)
      ADDR_CTRL: begin
        addr_ok                      = 1'b1;
        rd_word[NUM_PROTOCOLS-1:0]   = cfg_protocol_enable;
        rd_word[8]                   = cfg_pam4_enable;
        rd_word[9]                   = cfg_ml_optimization_enable;
        rd_word[10]                  = cfg_quarter_rate_enable;
      end
      ADDR_LINK_CFG: begin
        addr_ok       = 1'b1;
        rd_word[15:0] = {cfg_target_width, cfg_target_speed};
      end
      ADDR_FC_CFG: begin
        addr_ok = 1'b1;
        rd_word = {cfg_flow_control_timeout, 8'h00, cfg_credit_return_threshold};
      end
      ADDR_STATUS: begin
        addr_ok        = 1'b1;
        addr_ro        = 1'b1;
        rd_word[0]     = sts_link_up;
        rd_word[7:4]   = sts_link_state;
        rd_word[15:8]  = sts_current_speed;
        rd_word[16]    = sts_thermal_throttle;
      end
      ADDR_EVENT: begin
        addr_ok            = 1'b1;
        rd_word[EV_W-1:0]  = events;
      end
      ADDR_IRQ_EN: begin
        addr_ok            = 1'b1;
        rd_word[EV_W-1:0]  = irq_en;
      end
      ADDR_SNAP_CTRL: addr_ok = 1'b1;
      ADDR_SNAP_TX: begin
        addr_ok = 1'b1;
        addr_ro = 1'b1;
        rd_word = snap_tx;
      end
      ADDR_SNAP_RX: begin
        addr_ok = 1'b1;
        addr_ro = 1'b1;
        rd_word = snap_rx;
      end
      ADDR_SNAP_ERR: begin
        addr_ok = 1'b1;
        addr_ro = 1'b1;
        rd_word = snap_err;
      end
      ADDR_UPTIME: begin
        addr_ok = 1'b1;
        addr_ro = 1'b1;
        rd_word = uptime;
      end
      default: ;
    endcase
  end

  assign err_d     = !addr_ok || (csr_req_write && addr_ro);
  assign rdata_d   = (csr_req_write || err_d) ? '0 : rd_word;
  assign wr_word   = strobe_merge(rd_word, csr_req_wdata, csr_req_wstrb);
  assign do_wr     = accept && csr_req_write && !err_d;
  assign w1c_valid = do_wr && (csr_req_addr == ADDR_EVENT);
  assign w1c_mask  = csr_req_wdata[EV_W-1:0] & {EV_W{csr_req_wstrb[0]}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csr_rsp_rdata               <= '0;
      csr_rsp_err                 <= 1'b0;
      cfg_protocol_enable         <= '1;
      cfg_pam4_enable             <= 1'b0;
      cfg_ml_optimization_enable  <= 1'b0;
      cfg_quarter_rate_enable     <= 1'b0;
      cfg_target_speed            <= SPEED_RST;
      cfg_target_width            <= WIDTH_RST;
      cfg_credit_return_threshold <= CREDIT_RST;
      cfg_flow_control_timeout    <= FC_TIMEOUT_RST;
      irq_en                      <= '0;
      snap_tx                     <= '0;
      snap_rx                     <= '0;
      snap_err                    <= '0;
    end else begin
      if (accept) begin
        csr_rsp_rdata <= rdata_d;
        csr_rsp_err   <= err_d;
      end
      if (do_wr) begin
        case (csr_req_addr)
          ADDR_CTRL: begin
            cfg_protocol_enable        <= wr_word[NUM_PROTOCOLS-1:0];
            cfg_pam4_enable            <= wr_word[8];
            cfg_ml_optimization_enable <= wr_word[9];
            cfg_quarter_rate_enable    <= wr_word[10];
          end
          ADDR_LINK_CFG: begin
            cfg_target_speed <= wr_word[7:0];
            cfg_target_width <= wr_word[15:8];
          end
          ADDR_FC_CFG: begin
            cfg_credit_return_threshold <= wr_word[7:0];
            cfg_flow_control_timeout    <= wr_word[31:16];
          end
          ADDR_IRQ_EN: irq_en <= wr_word[EV_W-1:0];
          ADDR_SNAP_CTRL: begin
            if (csr_req_wstrb[0] && csr_req_wdata[0]) begin
              snap_tx  <= sts_packet_count_tx;
              snap_rx  <= sts_packet_count_rx;
              snap_err <= sts_error_count_total;
            end
          end
          default: ;
        endcase
      end
    end
  end

  ucie_csr_event_detect u_event_detect (
    .clk       (clk),
    .rst       (rst),
    .link_up   (sts_link_up),
    .thermal   (sts_thermal_throttle),
    .err_count (sts_error_count_total),
    .clr_valid (w1c_valid),
    .clr_mask  (w1c_mask),
    .events    (events),
    .uptime    (uptime)
  );

  assign irq = |(events & irq_en);

endmodule

// File: tb/tb_ucie_config_csr.sv
// Self-checking bench for ucie_config_csr: reset/error vector table, directed
// handshake and event sequences, then randomized accesses against a register model.
module tb_ucie_config_csr;

  logic        clk = 1'b0;
  logic        rst;
  logic        csr_req_valid;
  logic        csr_req_ready;
  logic        csr_req_write;
  logic [7:0]  csr_req_addr;
  logic [31:0] csr_req_wdata;
  logic [3:0]  csr_req_wstrb;
  logic        csr_rsp_valid;
  logic        csr_rsp_ready;
  logic [31:0] csr_rsp_rdata;
  logic        csr_rsp_err;
  logic [3:0]  cfg_protocol_enable;
  logic        cfg_pam4_enable;
  logic        cfg_ml_optimization_enable;
  logic        cfg_quarter_rate_enable;
  logic [7:0]  cfg_target_speed;
  logic [7:0]  cfg_target_width;
  logic [7:0]  cfg_credit_return_threshold;
  logic [15:0] cfg_flow_control_timeout;
  logic        sts_link_up;
  logic [3:0]  sts_link_state;
  logic [7:0]  sts_current_speed;
  logic        sts_thermal_throttle;
  logic [31:0] sts_packet_count_tx;
  logic [31:0] sts_packet_count_rx;
  logic [31:0] sts_error_count_total;
  logic        irq;

  ucie_config_csr #(
    .NUM_PROTOCOLS (4),
    .SPEED_RST     (8'd32),
    .WIDTH_RST     (8'd16)
  ) dut (
    .clk                         (clk),
    .rst                         (rst),
    .csr_req_valid               (csr_req_valid),
    .csr_req_ready               (csr_req_ready),
    .csr_req_write               (csr_req_write),
    .csr_req_addr                (csr_req_addr),
    .csr_req_wdata               (csr_req_wdata),
    .csr_req_wstrb               (csr_req_wstrb),
    .csr_rsp_valid               (csr_rsp_valid),
    .csr_rsp_ready               (csr_rsp_ready),
    .csr_rsp_rdata               (csr_rsp_rdata),
    .csr_rsp_err                 (csr_rsp_err),
    .cfg_protocol_enable         (cfg_protocol_enable),
    .cfg_pam4_enable             (cfg_pam4_enable),
    .cfg_ml_optimization_enable  (cfg_ml_optimization_enable),
    .cfg_quarter_rate_enable     (cfg_quarter_rate_enable),
    .cfg_target_speed            (cfg_target_speed),
    .cfg_target_width            (cfg_target_width),
    .cfg_credit_return_threshold (cfg_credit_return_threshold),
    .cfg_flow_control_timeout    (cfg_flow_control_timeout),
    .sts_link_up                 (sts_link_up),
    .sts_link_state              (sts_link_state),
    .sts_current_speed           (sts_current_speed),
    .sts_thermal_throttle        (sts_thermal_throttle),
    .sts_packet_count_tx         (sts_packet_count_tx),
    .sts_packet_count_rx         (sts_packet_count_rx),
    .sts_error_count_total       (sts_error_count_total),
    .irq                         (irq)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  // Register model (specification-level view of the map)
  logic [31:0] m_ctrl, m_link, m_fc, m_irq_en, m_snap_tx, m_snap_rx, m_snap_err;
  logic [2:0]  m_ev;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input logic [31:0] act,
                             input logic [31:0] lo, input logic [31:0] hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic access(input logic wr, input logic [7:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic drop_link,
                        output logic [31:0] rd, output logic er);
    int n;
    @(negedge clk);
    n = 0;
    while (!csr_req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!csr_req_ready) check("req_ready_timeout", {31'b0, csr_req_ready}, 32'd1);
    csr_req_valid = 1'b1;
    csr_req_write = wr;
    csr_req_addr  = a;
    csr_req_wdata = d;
    csr_req_wstrb = s;
    csr_rsp_ready = 1'b1;
    if (drop_link) sts_link_up = 1'b0;
    @(posedge clk);
    #1;
    csr_req_valid = 1'b0;
    n = 0;
    while (!csr_rsp_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!csr_rsp_valid) check("rsp_valid_timeout", {31'b0, csr_rsp_valid}, 32'd1);
    rd = csr_rsp_rdata;
    er = csr_rsp_err;
    @(posedge clk);
    #1;
  endtask

  // Issue one access with rsp_ready low for three cycles; response must hold steady.
  task automatic hold_check(input logic wr, input logic [7:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic [31:0] exp_rd);
    @(negedge clk);
    csr_rsp_ready = 1'b0;
    csr_req_valid = 1'b1;
    csr_req_write = wr;
    csr_req_addr  = a;
    csr_req_wdata = d;
    csr_req_wstrb = s;
    @(posedge clk);
    #1;
    csr_req_valid = 1'b0;
    check("hold_latency_valid", {31'b0, csr_rsp_valid}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("hold%0d_valid", k), {31'b0, csr_rsp_valid}, 32'd1);
      check($sformatf("hold%0d_rdata", k), csr_rsp_rdata, exp_rd);
      check($sformatf("hold%0d_ready", k), {31'b0, csr_req_ready}, 32'd0);
    end
    @(negedge clk);
    csr_rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("hold_release_valid", {31'b0, csr_rsp_valid}, 32'd0);
    check("hold_release_ready", {31'b0, csr_req_ready}, 32'd1);
  endtask

  function automatic logic [31:0] byte_mask(input logic [3:0] s);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{s[i]}};
    return m;
  endfunction

  function automatic logic [31:0] m_read(input logic [7:0] a);
    case (a)
      8'h00: return m_ctrl;
      8'h04: return m_link;
      8'h08: return m_fc;
      8'h10: return {15'b0, sts_thermal_throttle, sts_current_speed, sts_link_state, 3'b0, sts_link_up};
      8'h14: return {29'b0, m_ev};
      8'h18: return m_irq_en;
      8'h24: return m_snap_tx;
      8'h28: return m_snap_rx;
      8'h2C: return m_snap_err;
      default: return 32'h0;  // SNAP_CTRL, and UPTIME while the link stays down
    endcase
  endfunction

  function automatic logic m_mapped(input logic [7:0] a);
    return a inside {8'h00, 8'h04, 8'h08, 8'h10, 8'h14, 8'h18, 8'h20,
                     8'h24, 8'h28, 8'h2C, 8'h30};
  endfunction

  function automatic logic m_readonly(input logic [7:0] a);
    return a inside {8'h10, 8'h24, 8'h28, 8'h2C, 8'h30};
  endfunction

  task automatic m_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] bm;
    bm = byte_mask(s);
    case (a)
      8'h00: m_ctrl   = (m_ctrl   & ~(bm & 32'h0000_070F)) | (d & bm & 32'h0000_070F);
      8'h04: m_link   = (m_link   & ~(bm & 32'h0000_FFFF)) | (d & bm & 32'h0000_FFFF);
      8'h08: m_fc     = (m_fc     & ~(bm & 32'hFFFF_00FF)) | (d & bm & 32'hFFFF_00FF);
      8'h18: m_irq_en = (m_irq_en & ~(bm & 32'h7)) | (d & bm & 32'h7);
      8'h14: if (s[0]) m_ev = m_ev & ~d[2:0];
      8'h20: if (s[0] && d[0]) begin
        m_snap_tx  = sts_packet_count_tx;
        m_snap_rx  = sts_packet_count_rx;
        m_snap_err = sts_error_count_total;
      end
      default: ;
    endcase
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    logic [7:0]  pool [16];
    logic        wr;
    logic [7:0]  a;
    logic [31:0] d;
    logic [3:0]  s;
    logic [31:0] exp_rd;
    logic        exp_er;
    logic        new_th;
    logic [31:0] new_err;

    csr_req_valid = 1'b0;
    csr_req_write = 1'b0;
    csr_req_addr  = 8'h00;
    csr_req_wdata = 32'h0;
    csr_req_wstrb = 4'h0;
    csr_rsp_ready = 1'b1;
    sts_link_up   = 1'b0;
    sts_link_state = 4'h3;
    sts_current_speed = 8'h20;
    // Thermal high and a nonzero error count at reset release must not raise events.
    sts_thermal_throttle  = 1'b1;
    sts_packet_count_tx   = 32'h0;
    sts_packet_count_rx   = 32'h0;
    sts_error_count_total = 32'h5;
    rst = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", {31'b0, csr_req_ready}, 32'd0);
    check("rst_rsp_valid", {31'b0, csr_rsp_valid}, 32'd0);
    check("rst_irq",       {31'b0, irq}, 32'd0);
    check("rst_rdata",     csr_rsp_rdata, 32'd0);
    check("rst_err",       {31'b0, csr_rsp_err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_ready", {31'b0, csr_req_ready}, 32'd1);
    check("rst_speed",   {24'b0, cfg_target_speed}, 32'd32);
    check("rst_width",   {24'b0, cfg_target_width}, 32'd16);
    check("rst_prot",    {28'b0, cfg_protocol_enable}, 32'hF);
    check("rst_timeout", {16'b0, cfg_flow_control_timeout}, 32'hFFFF);
    check("rst_credit",  {24'b0, cfg_credit_return_threshold}, 32'd8);
    check("rst_ctrl_bits", {29'b0, cfg_quarter_rate_enable, cfg_ml_optimization_enable, cfg_pam4_enable}, 32'd0);

    // wr, addr, wdata, wstrb, expected rdata, expected err
    vecs.push_back('{1'b0, 8'h08, 32'h0,         4'hF, 32'hFFFF_0008, 1'b0});
    vecs.push_back('{1'b0, 8'h04, 32'h0,         4'hF, 32'h0000_1020, 1'b0});
    vecs.push_back('{1'b0, 8'h00, 32'h0,         4'hF, 32'h0000_000F, 1'b0});
    vecs.push_back('{1'b0, 8'h18, 32'h0,         4'hF, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b0, 8'h14, 32'h0,         4'hF, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b0, 8'h10, 32'h0,         4'hF, 32'h0001_2030, 1'b0});
    vecs.push_back('{1'b0, 8'h3C, 32'h0,         4'hF, 32'h0000_0000, 1'b1});
    vecs.push_back('{1'b1, 8'h10, 32'hFFFF_FFFF, 4'hF, 32'h0000_0000, 1'b1});
    vecs.push_back('{1'b0, 8'h06, 32'h0,         4'hF, 32'h0000_0000, 1'b1});
    vecs.push_back('{1'b1, 8'h0C, 32'hFFFF_FFFF, 4'hF, 32'h0000_0000, 1'b1});
    vecs.push_back('{1'b1, 8'h05, 32'hFFFF_FFFF, 4'hF, 32'h0000_0000, 1'b1});
    vecs.push_back('{1'b1, 8'h04, 32'h0000_4040, 4'h1, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b0, 8'h04, 32'h0,         4'hF, 32'h0000_1040, 1'b0});
    vecs.push_back('{1'b1, 8'h08, 32'hABCD_1234, 4'hC, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b0, 8'h08, 32'h0,         4'hF, 32'hABCD_0008, 1'b0});
    vecs.push_back('{1'b1, 8'h00, 32'hFFFF_FFFF, 4'h2, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b0, 8'h00, 32'h0,         4'hF, 32'h0000_070F, 1'b0});
    vecs.push_back('{1'b1, 8'h18, 32'h0000_0007, 4'h0, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b0, 8'h18, 32'h0,         4'hF, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b0, 8'h20, 32'h0,         4'hF, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b0, 8'h24, 32'h0,         4'hF, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b0, 8'h30, 32'h0,         4'hF, 32'h0000_0000, 1'b0});

    foreach (vecs[i]) begin
      access(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, 1'b0, rd, er);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("vec%0d_err", i), {31'b0, er}, {31'b0, vecs[i].exp_err});
    end
    check("tbl_speed",   {24'b0, cfg_target_speed}, 32'h40);
    check("tbl_width",   {24'b0, cfg_target_width}, 32'd16);
    check("tbl_timeout", {16'b0, cfg_flow_control_timeout}, 32'hABCD);
    check("tbl_credit",  {24'b0, cfg_credit_return_threshold}, 32'd8);
    check("tbl_ctrl", {21'b0, cfg_quarter_rate_enable, cfg_ml_optimization_enable,
                       cfg_pam4_enable, 4'b0, cfg_protocol_enable}, 32'h0000_070F);

    // Held response: write effect visible at N+1, response stable while rsp_ready low.
    hold_check(1'b1, 8'h04, 32'h0000_5050, 4'h1, 32'h0);
    check("hold_wr_speed", {24'b0, cfg_target_speed}, 32'h50);
    check("hold_wr_width", {24'b0, cfg_target_width}, 32'd16);
    hold_check(1'b0, 8'h04, 32'h0, 4'hF, 32'h0000_1050);

    // Uptime: link up for 100 cycles; reading any value in 99..101 is accepted.
    @(negedge clk);
    sts_link_up = 1'b1;
    repeat (100) @(posedge clk);
    access(1'b0, 8'h30, 32'h0, 4'hF, 1'b0, rd, er);
    check_range("uptime_100", rd, 32'd99, 32'd101);
    access(1'b1, 8'h18, 32'h1, 4'hF, 1'b0, rd, er);
    access(1'b0, 8'h14, 32'h0, 4'hF, 1'b0, rd, er);
    check("ev_before_fall", rd, 32'h0);
    check("irq_before_fall", {31'b0, irq}, 32'd0);
    @(negedge clk);
    sts_link_up = 1'b0;
    access(1'b0, 8'h30, 32'h0, 4'hF, 1'b0, rd, er);
    check("uptime_after_fall", rd, 32'h0);
    access(1'b0, 8'h14, 32'h0, 4'hF, 1'b0, rd, er);
    check("ev_link_down", rd, 32'h1);
    check("irq_link_down", {31'b0, irq}, 32'd1);
    access(1'b1, 8'h14, 32'h1, 4'h0, 1'b0, rd, er);
    access(1'b0, 8'h14, 32'h0, 4'hF, 1'b0, rd, er);
    check("w1c_no_strobe", rd, 32'h1);
    access(1'b1, 8'h14, 32'h1, 4'hF, 1'b0, rd, er);
    check("irq_after_w1c", {31'b0, irq}, 32'd0);
    access(1'b0, 8'h14, 32'h0, 4'hF, 1'b0, rd, er);
    check("ev_after_w1c", rd, 32'h0);
    // New fall on the same edge as the clear: the set must win.
    @(negedge clk);
    sts_link_up = 1'b1;
    repeat (3) @(posedge clk);
    access(1'b1, 8'h14, 32'h1, 4'h1, 1'b1, rd, er);
    check("irq_set_wins", {31'b0, irq}, 32'd1);
    access(1'b0, 8'h14, 32'h0, 4'hF, 1'b0, rd, er);
    check("ev_set_wins", rd, 32'h1);

    // Snapshot capture and hold.
    @(negedge clk);
    sts_packet_count_tx   = 32'h1234;
    sts_packet_count_rx   = 32'h55;
    sts_error_count_total = 32'h77;
    access(1'b1, 8'h20, 32'h1, 4'h1, 1'b0, rd, er);
    check("snap_wr_err", {31'b0, er}, 32'd0);
    sts_packet_count_tx = 32'h9999;
    access(1'b0, 8'h24, 32'h0, 4'hF, 1'b0, rd, er);
    check("snap_tx", rd, 32'h1234);
    access(1'b0, 8'h28, 32'h0, 4'hF, 1'b0, rd, er);
    check("snap_rx", rd, 32'h55);
    access(1'b0, 8'h2C, 32'h0, 4'hF, 1'b0, rd, er);
    check("snap_err", rd, 32'h77);
    access(1'b1, 8'h20, 32'h1, 4'h2, 1'b0, rd, er);
    access(1'b0, 8'h24, 32'h0, 4'hF, 1'b0, rd, er);
    check("snap_no_strobe", rd, 32'h1234);
    access(1'b0, 8'h14, 32'h0, 4'hF, 1'b0, rd, er);
    check("ev_error_set", rd, 32'h5);

    // Reset in the middle of a pending response.
    @(negedge clk);
    csr_rsp_ready = 1'b0;
    csr_req_valid = 1'b1;
    csr_req_write = 1'b0;
    csr_req_addr  = 8'h08;
    @(posedge clk);
    #1;
    csr_req_valid = 1'b0;
    check("mid_rst_pending", {31'b0, csr_rsp_valid}, 32'd1);
    #2;
    rst = 1'b1;
    sts_link_up = 1'b0;
    #1;
    check("mid_rst_valid", {31'b0, csr_rsp_valid}, 32'd0);
    check("mid_rst_ready", {31'b0, csr_req_ready}, 32'd0);
    check("mid_rst_rdata", csr_rsp_rdata, 32'd0);
    check("mid_rst_speed", {24'b0, cfg_target_speed}, 32'd32);
    check("mid_rst_irq",   {31'b0, irq}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    csr_rsp_ready = 1'b1;
    #1;
    check("mid_rst_release_ready", {31'b0, csr_req_ready}, 32'd1);

    // Randomized accesses against the register model (link held down).
    m_ctrl = 32'h0000_000F;
    m_link = 32'h0000_1020;
    m_fc   = 32'hFFFF_0008;
    m_irq_en = 32'h0;
    m_ev = 3'b000;
    m_snap_tx = 32'h0;
    m_snap_rx = 32'h0;
    m_snap_err = 32'h0;
    pool = '{8'h00, 8'h04, 8'h08, 8'h10, 8'h14, 8'h18, 8'h20, 8'h24,
             8'h28, 8'h2C, 8'h30, 8'h0C, 8'h1C, 8'h3C, 8'h06, 8'h01};
    for (int it = 0; it < 300; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        new_th  = 1'($urandom_range(0, 1));
        new_err = ($urandom_range(0, 1) == 1) ? $urandom : sts_error_count_total;
        if (!sts_thermal_throttle && new_th) m_ev[1] = 1'b1;
        if (new_err != sts_error_count_total) m_ev[2] = 1'b1;
        sts_thermal_throttle  = new_th;
        sts_error_count_total = new_err;
        sts_packet_count_tx   = $urandom;
        sts_packet_count_rx   = $urandom;
        sts_link_state        = 4'($urandom);
        sts_current_speed     = 8'($urandom);
        repeat (2) @(posedge clk);
      end
      wr = 1'($urandom_range(0, 1));
      a  = pool[$urandom_range(0, 15)];
      d  = $urandom;
      s  = 4'($urandom);
      if (a == 8'h14 && $urandom_range(0, 1) == 1) d = 32'h7;
      exp_er = !m_mapped(a) || (wr && m_readonly(a));
      exp_rd = (wr || exp_er) ? 32'h0 : m_read(a);
      access(wr, a, d, s, 1'b0, rd, er);
      check($sformatf("rnd%0d_a%h_rdata", it, a), rd, exp_rd);
      check($sformatf("rnd%0d_a%h_err", it, a), {31'b0, er}, {31'b0, exp_er});
      if (wr && !exp_er) m_write(a, d, s);
      check($sformatf("rnd%0d_irq", it), {31'b0, irq}, {31'b0, |(m_ev & m_irq_en[2:0])});
      check($sformatf("rnd%0d_ctrl", it),
            {21'b0, cfg_quarter_rate_enable, cfg_ml_optimization_enable,
             cfg_pam4_enable, 4'b0, cfg_protocol_enable}, m_ctrl);
      check($sformatf("rnd%0d_link", it), {16'b0, cfg_target_width, cfg_target_speed}, m_link);
      check($sformatf("rnd%0d_fc", it),
            {cfg_flow_control_timeout, 8'b0, cfg_credit_return_threshold}, m_fc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
